// File: rtl/bcd_scan_pkg.sv
// Shared constants and helpers for the BCD scan counter: active-low
// seven-segment codes ({a,b,c,d,e,f,g} on [6:0]), the blank code and
// small per-digit functions used by both the counter and the display mux.
package bcd_scan_pkg;

    localparam logic [6:0] Seg0     = 7'b0000001;
    localparam logic [6:0] Seg1     = 7'b1001111;
    localparam logic [6:0] Seg2     = 7'b0010010;
    localparam logic [6:0] Seg3     = 7'b0000110;
    localparam logic [6:0] Seg4     = 7'b1001100;
    localparam logic [6:0] Seg5     = 7'b0100100;
    localparam logic [6:0] Seg6     = 7'b0100000;
    localparam logic [6:0] Seg7     = 7'b0001111;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0000100;
    localparam logic [6:0] SegBlank = 7'b1111111;

    // Non-BCD codes (10..15) never reach the display; show them blank anyway.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = Seg0;
            4'd1:    code = Seg1;
            4'd2:    code = Seg2;
            4'd3:    code = Seg3;
            4'd4:    code = Seg4;
            4'd5:    code = Seg5;
            4'd6:    code = Seg6;
            4'd7:    code = Seg7;
            4'd8:    code = Seg8;
            4'd9:    code = Seg9;
            default: code = SegBlank;
        endcase
        return code;
    endfunction

    // Clamp a nibble to a legal BCD digit.
    function automatic logic [3:0] sat_digit(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

endpackage

// File: rtl/bcd_scan_mux.sv
// Multiplexed display driver: walks the digit index every SCAN_DIV cycles and
// registers the active-low anode and segment outputs for the selected digit.
// Optional macro BCD_SCAN_BLANK_EN blanks leading zero digits (never digit 0).
module bcd_scan_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 400_000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] count_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   ga_o
);
    import bcd_scan_pkg::*;

    localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TW-1:0]         tmr_q, tmr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] ga_q, ga_d;
    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            digit;

`ifdef BCD_SCAN_BLANK_EN
    // Blank a digit when it and every digit above it are zero.
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lead     = lead & (count_i[4*k +: 4] == 4'd0);
            blank[k] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    // Scan timer/index advance and the decode of the currently selected digit.
    always_comb begin
        tmr_d = tmr_q + 1'b1;
        idx_d = idx_q;
        if (tmr_q == TW'(SCAN_DIV - 1)) begin
            tmr_d = '0;
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        digit = count_i[4*idx_q +: 4];
        ga_d  = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = blank[idx_q] ? SegBlank : bcd_to_seg(digit);
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmr_q <= '0;
            idx_q <= '0;
            seg_q <= SegBlank;
            ga_q  <= '1;
        end else begin
            tmr_q <= tmr_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            ga_q  <= ga_d;
        end
    end

    assign seg_o = seg_q;
    assign ga_o  = ga_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaled count steps, synchronous
// clear/load and a scanned seven-segment display (bcd_scan_mux).
// Optional macro BCD_SCAN_BLANK_EN enables leading-zero blanking.
module bcd_scan_counter #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned SCAN_DIV   = 400_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   ga
);
    import bcd_scan_pkg::*;

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned CW = 4 * NUM_DIGITS;

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inc_val, dec_val, sat_val;
    logic          wrap_q, wrap_d;
    logic          inc_wrap, dec_wrap;
    logic          tick;

    assign tick = en & (presc_q == PW'(TICK_DIV - 1));

    // Candidate next counts: ripple-carry increment, ripple-borrow decrement, clamped load.
    always_comb begin
        logic carry;
        logic borrow;
        carry   = 1'b1;
        borrow  = 1'b1;
        inc_val = count_q;
        dec_val = count_q;
        sat_val = load_val;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
            sat_val[4*k +: 4] = sat_digit(load_val[4*k +: 4]);
        end
        // Carry/borrow out of the top digit means all-9s or all-0s rolled over.
        inc_wrap = carry;
        dec_wrap = borrow;
    end

    // Next state with priority clr > load > tick; only a tick can wrap.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            presc_d = '0;
            count_d = '0;
        end else if (load) begin
            presc_d = '0;
            count_d = sat_val;
        end else if (tick) begin
            presc_d = '0;
            count_d = up_dn ? inc_val : dec_val;
            wrap_d  = up_dn ? inc_wrap : dec_wrap;
        end else if (en) begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;

    bcd_scan_mux #(
        .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV  (SCAN_DIV)
    ) u_scan_mux (
        .clk_i  (clk),
        .rst_i  (rst),
        .count_i(count_q),
        .seg_o  (seg),
        .ga_o   (ga)
    );

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter (4 digits, TICK_DIV=4, SCAN_DIV=2).
// A decimal-integer reference model predicts each cycle's outputs, pushes
// them to a queue before the clock edge and pops/compares them after it.
module tb_bcd_scan_counter;

    localparam int ND      = 4;
    localparam int TD      = 4;
    localparam int SD      = 2;
    localparam int MAX_CNT = 9999;

    logic        clk = 1'b0;
    logic        rst, en, up_dn, clr, load;
    logic [15:0] load_val;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [6:0]  seg;
    logic [3:0]  ga;

    bcd_scan_counter #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (TD),
        .SCAN_DIV  (SD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count_bcd(count_bcd),
        .wrap     (wrap),
        .seg      (seg),
        .ga       (ga)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] cnt;
        logic        wrap;
        logic [3:0]  ga;
        logic [6:0]  seg;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (decimal count, prescaler, scan position).
    int m_cnt, m_presc, m_idx, m_tmr;

    logic [6:0] dec_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r *= 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    function automatic int sat_load(input logic [15:0] v);
        int acc = 0;
        int d;
        for (int k = 0; k < ND; k++) begin
            d = int'(v[4*k +: 4]);
            if (d > 9) d = 9;
            acc += d * pow10(k);
        end
        return acc;
    endfunction

    function automatic logic [6:0] seg_of(input int cnt, input int k);
`ifdef BCD_SCAN_BLANK_EN
        if (k > 0 && cnt < pow10(k)) return 7'b1111111;
`endif
        return dec_tab[(cnt / pow10(k)) % 10];
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_presc = 0;
        m_idx   = 0;
        m_tmr   = 0;
    endtask

    // Predict the next edge from current inputs, then compare after the edge.
    task automatic step();
        exp_t       e;
        exp_t       got_e;
        logic [3:0] one = 4'b0001;
        logic       nwrap = 1'b0;
        e.ga  = ~(one << m_idx);
        e.seg = seg_of(m_cnt, m_idx);
        if (clr) begin
            m_cnt   = 0;
            m_presc = 0;
        end else if (load) begin
            m_cnt   = sat_load(load_val);
            m_presc = 0;
        end else if (en) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                if (up_dn) begin
                    nwrap = (m_cnt == MAX_CNT);
                    m_cnt = (m_cnt + 1) % (MAX_CNT + 1);
                end else begin
                    nwrap = (m_cnt == 0);
                    m_cnt = (m_cnt == 0) ? MAX_CNT : m_cnt - 1;
                end
            end else begin
                m_presc++;
            end
        end
        e.cnt  = to_bcd(m_cnt);
        e.wrap = nwrap;
        if (m_tmr == SD - 1) begin
            m_tmr = 0;
            m_idx = (m_idx + 1) % ND;
        end else begin
            m_tmr++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = exp_q.pop_front();
        check("count", 32'(count_bcd), 32'(got_e.cnt));
        check("wrap",  32'(wrap),      32'(got_e.wrap));
        check("ga",    32'(ga),        32'(got_e.ga));
        check("seg",   32'(seg),       32'(got_e.seg));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(count_bcd), 32'h0);
        check({tag, "_wrap"},  32'(wrap),      32'h0);
        check({tag, "_seg"},   32'(seg),       32'h7f);
        check({tag, "_ga"},    32'(ga),        32'hf);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        #12;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Count up from zero for 40 cycles.
        en    = 1'b1;
        up_dn = 1'b1;
        repeat (40) step();
        check("up40_count", 32'(count_bcd), 32'h0010);

        // Roll-over from 9999 and roll-under from 0000, direction changed mid-prescale.
        load     = 1'b1;
        load_val = 16'h9998;
        step();
        load = 1'b0;
        repeat (10) step();
        up_dn = 1'b0;
        repeat (5) step();
        check("dn_wrap_count", 32'(count_bcd), 32'h9999);

        // clr beats load; load saturates non-BCD digits.
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 16'h1234;
        step();
        clr  = 1'b0;
        load = 1'b0;
        check("clr_load_count", 32'(count_bcd), 32'h0000);
        load     = 1'b1;
        load_val = 16'hFA12;
        step();
        load = 1'b0;
        check("sat_load_count", 32'(count_bcd), 32'h9912);

        // Frozen count, watch the scan sequence.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 16'h0305;
        step();
        load = 1'b0;
        repeat (12) step();
        check("frozen_count", 32'(count_bcd), 32'h0305);

        // Asynchronous reset mid-prescale and mid-scan.
        en       = 1'b1;
        up_dn    = 1'b1;
        load     = 1'b1;
        load_val = 16'h0042;
        step();
        load = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) step();
        check("resume_hold", 32'(count_bcd), 32'h0000);
        step();
        check("resume_step", 32'(count_bcd), 32'h0001);

        // Random mix of enable, direction, clear and load.
        repeat (300) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = $urandom_range(0, 1) == 1;
            clr      = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 11) == 0);
            load_val = 16'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD digits (range 1..8).
REQ-002 SHALL have parameter TICK_DIV, default 100_000_000, clk cycles per count step (>=2).
REQ-003 SHALL have parameter SCAN_DIV, default 400_000, clk cycles each digit is driven (>=1).
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port en, input, 1, count enable; low freezes prescaler and count.
REQ-007 SHALL have port up_dn, input, 1, direction: 1 = up, 0 = down.
REQ-008 SHALL have port clr, input, 1, synchronous clear of count and prescaler.
REQ-009 SHALL have port load, input, 1, synchronous load of load_val.
REQ-010 SHALL have port load_val, input, 4*NUM_DIGITS, BCD load value; digit 0 in bits [3:0].
REQ-011 SHALL have port count_bcd, output, 4*NUM_DIGITS, current count; digit 0 = least significant.
REQ-012 SHALL have port wrap, output, 1, one-cycle pulse on roll-over or roll-under.
REQ-013 SHALL have port seg, output, 7, segments {a,b,c,d,e,f,g} on [6:0], active-low.
REQ-014 SHALL have port ga, output, NUM_DIGITS, digit anodes, active-low, at most one low.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 while en=1 and assert an internal tick in its TICK_DIV-1 cycle, then return to 0.
REQ-016 Priority per cycle SHALL be clr > load > tick; clr zeroes count and prescaler; load zeroes the prescaler.
REQ-017 load SHALL saturate each load_val digit above 9 to 9.
REQ-018 On tick with up_dn=1, count SHALL increment in BCD with ripple carry; all-9s SHALL become all-0s and assert wrap.
REQ-019 On tick with up_dn=0, count SHALL decrement in BCD with borrow; all-0s SHALL become all-9s and assert wrap.
REQ-020 wrap SHALL be high exactly the cycle after the wrapping tick; clr/load SHALL never assert wrap.
REQ-021 count_bcd SHALL update the cycle after the tick, clr or load edge.
REQ-022 The scan index SHALL advance 0..NUM_DIGITS-1 cyclically every SCAN_DIV cycles, independent of en, clr and load.
REQ-023 While index k is active, ga[k] SHALL be 0, all other ga bits 1, and seg SHALL be the decode of digit k.
REQ-024 seg and ga SHALL be registered: one cycle latency from count/index change.
REQ-025 Decode table (abcdefg, active-low) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-026 A change of up_dn mid-prescale SHALL take effect at the next tick without resetting the prescaler.

Reset
REQ-027 rst high SHALL immediately force count_bcd=0, wrap=0, seg=1111111, ga all 1s, prescaler=0, scan index=0, scan timer=0.
REQ-028 After rst release, the first clk edge SHALL load ga/seg for digit 0; the count SHALL not step before a full TICK_DIV cycles of en.
REQ-029 rst asserted mid-scan or mid-prescale SHALL discard all partial progress.

Configuration
REQ-030 With macro BCD_SCAN_BLANK_EN defined, leading zero digits (above the most significant non-zero digit; digit 0 never) SHALL drive seg=1111111 while ga is still scanned.
REQ-031 Without BCD_SCAN_BLANK_EN, every digit SHALL display its decoded value, including leading zeros.

Structure
REQ-032 Shared package bcd_scan_pkg SHALL hold the segment code constants, the blank code 1111111 and the digit-to-seg decode function.
REQ-033 The display scanning (scan timer, index, ga/seg registers) SHALL be sub-module bcd_scan_mux; counting stays in the top module.

Verification (NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless stated)
REQ-034 Reset then en=1, up_dn=1 for 40 cycles -> count_bcd 0x0000 to 0x0010 in steps every 4 cycles, wrap never high.
REQ-035 load 0x9998, up -> 0x9999 then 0x0000 with wrap high exactly one cycle; down from 0x0000 -> 0x9999 with wrap.
REQ-036 clr and load (load_val=0x1234) same cycle -> count 0x0000; load_val=0xFA12 alone -> count 0x9912.
REQ-037 count 0x0305, en=0 -> ga sequence 1110,1101,1011,0111, each 2 cycles; seg 0100100,0000001,0000110,0000001; leading digit 1111111 when BCD_SCAN_BLANK_EN defined.
REQ-038 rst pulsed mid-prescale and mid-scan (count 0x0042) -> outputs at reset values within the same cycle, count resumes from 0x0000 after 4 enabled cycles.
